// File: rtl/s8sp_pkg.sv
// s8sp_pkg: shared encodings for the ALU arbiter slice
package s8sp_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant, ptr wins only on contention
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant = (req_valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req_valid;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one add/sub alu_block between two requesters and owns the NZCV flags
module alu_arbiter
  import s8sp_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter logic [3:0] FLAG_MASK = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic              alu_sub_nadd,
  input  logic [DATA_W:0]   alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        flags
);
  logic [1:0]        state;
  logic              ptr;
  logic [1:0]        grant;
  logic              gidx;
  logic [DATA_W-1:0] s;
  logic              a7, b7, s7;
  logic [3:0]        nf;

  rr_arb2 u_arb (.req_valid(req_valid), .ptr(ptr), .grant(grant));

  assign req_ready = (reset && state == IDLE) ? grant : 2'b00;
  assign gidx      = grant[1];
  assign s         = alu_result[DATA_W-1:0];
  assign a7        = alu_in1[DATA_W-1];
  assign b7        = alu_in2[DATA_W-1];
  assign s7        = s[DATA_W-1];

  // overflow: operands effectively same-signed (b inverted for sub) yet result sign flips
  always_comb begin
    nf         = 4'b0000;
    nf[FLAG_N] = s7;
    nf[FLAG_Z] = (s == '0);
    nf[FLAG_C] = alu_result[DATA_W];
    nf[FLAG_V] = (alu_sub_nadd == OP_SUB) ? ((a7 != b7) && (s7 != a7)) : ((a7 == b7) && (s7 != a7));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      flags        <= 4'b0000;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_sub_nadd <= 1'b0;
    end else if (state == IDLE) begin
      if (|req_ready) begin
        alu_in1      <= gidx ? req1_a : req0_a;
        alu_in2      <= gidx ? req1_b : req0_b;
        alu_sub_nadd <= gidx ? req1_sub : req0_sub;
        rsp_id       <= gidx;
        ptr          <= ~gidx;
        state        <= EXEC;
      end
    end else if (state == EXEC) begin
      rsp_data  <= s;
      rsp_valid <= 1'b1;
      flags     <= (flags & ~FLAG_MASK) | (nf & FLAG_MASK);
      state     <= RESP;
    end else if (state == RESP) begin
      if (rsp_ready) begin
        rsp_valid <= 1'b0;
        state     <= IDLE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench with an arithmetic reference model
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
  logic       req0_sub = 1'b0, req1_sub = 1'b0;
  logic       rsp_ready = 1'b1;

  logic [1:0] req_ready, req_ready_m;
  logic [7:0] alu_in1, alu_in2, alu_in1_m, alu_in2_m;
  logic       alu_sub_nadd, alu_sub_nadd_m;
  logic [8:0] alu_result, alu_result_m;
  logic       rsp_valid, rsp_valid_m, rsp_id, rsp_id_m;
  logic [7:0] rsp_data, rsp_data_m;
  logic [3:0] flags, flags_m;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] m1 = 4'b0000;
  logic [3:0] m2 = 4'b0000;
  logic       mptr = 1'b0;

  always #5 clk = ~clk;

  // behavioural alu_block for each instance
  assign alu_result   = alu_sub_nadd ? ({1'b0, alu_in1} + {1'b0, ~alu_in2} + 9'd1) : ({1'b0, alu_in1} + {1'b0, alu_in2});
  assign alu_result_m = alu_sub_nadd_m ? ({1'b0, alu_in1_m} + {1'b0, ~alu_in2_m} + 9'd1) : ({1'b0, alu_in1_m} + {1'b0, alu_in2_m});

  alu_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sub_nadd(alu_sub_nadd), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .flags(flags)
  );

  alu_arbiter #(.FLAG_MASK(4'b0100)) dut_m (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_m),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .alu_in1(alu_in1_m), .alu_in2(alu_in2_m), .alu_sub_nadd(alu_sub_nadd_m), .alu_result(alu_result_m),
    .rsp_valid(rsp_valid_m), .rsp_ready(rsp_ready), .rsp_id(rsp_id_m), .rsp_data(rsp_data_m), .flags(flags_m)
  );

  // reference: {N,Z,C,V} and result byte from plain integer arithmetic
  function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r = sub ? ua - ub : ua + ub;
    int sr = sub ? sa - sb : sa + sb;
    logic [7:0] s = 8'((r % 256 + 256) % 256);
    logic c = sub ? (ua >= ub) : (r > 255);
    logic v = (sr > 127) || (sr < -128);
    return {s[7], s == 8'h00, c, v, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  task automatic accept(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub, output int waited);
    drive(id, a, b, sub);
    req_valid[id] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[id] && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    req_valid[id] = 1'b0;
    mptr = ~1'(id);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 2'b11;
    repeat (3) tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (flags !== 4'b0000 || flags_m !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b/%b exp=0000", flags, flags_m); end
    n_checks++; if (alu_in1 !== 8'h00 || alu_in2 !== 8'h00) begin n_fail++; $display("FAIL reset_alu_in got=%h/%h exp=00/00", alu_in1, alu_in2); end
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL release_ready got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    m1 = 4'b0000; m2 = 4'b0000; mptr = 1'b0;
  endtask

  task automatic test_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub);
    int w;
    logic [11:0] e;
    e = ref_op(a, b, sub);
    accept(id, a, b, sub, w);
    n_checks++; if (w >= 20) begin n_fail++; $display("FAIL op_accept_timeout id=%0d waited=%0d exp<20", id, w); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL op_early_valid got=%b exp=0", rsp_valid); end
    n_checks++; if ({alu_in1, alu_in2, alu_sub_nadd} !== {a, b, sub}) begin n_fail++; $display("FAIL op_alu_in got=%h,%h,%b exp=%h,%h,%b", alu_in1, alu_in2, alu_sub_nadd, a, b, sub); end
    tick();
    m1 = e[11:8];
    m2 = (m2 & 4'b1011) | (e[11:8] & 4'b0100);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(id)) begin n_fail++; $display("FAIL op_rsp got valid=%b id=%b exp valid=1 id=%0d", rsp_valid, rsp_id, id); end
    n_checks++; if (rsp_data !== e[7:0]) begin n_fail++; $display("FAIL op_data %h%s%h got=%h exp=%h", a, sub ? "-" : "+", b, rsp_data, e[7:0]); end
    n_checks++; if (flags !== m1 || flags_m !== m2) begin n_fail++; $display("FAIL op_flags got=%b/%b exp=%b/%b", flags, flags_m, m1, m2); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL op_rsp_clear got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [2], b [2];
    logic       sb [2];
    int         q [$];
    int         last = -1;
    int         acc = 0;
    int         rsps = 0;
    logic [11:0] e;
    for (int i = 0; i < 2; i++) begin
      a[i] = 8'($urandom); b[i] = 8'($urandom); sb[i] = 1'($urandom);
      drive(i, a[i], b[i], sb[i]);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc == 12) begin
        req_valid = 2'b00;
        #1;
      end
      if (rsp_valid) begin
        rsps++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious_rsp id=%b exp=none", rsp_id);
        end else begin
          int id = q.pop_front();
          e = ref_op(a[id], b[id], sb[id]);
          m1 = e[11:8];
          m2 = (m2 & 4'b1011) | (e[11:8] & 4'b0100);
          if (rsp_id !== 1'(id) || rsp_data !== e[7:0] || flags !== m1 || flags_m !== m2) begin
            n_fail++; $display("FAIL b2b_rsp got id=%b data=%h flags=%b/%b exp id=%0d data=%h flags=%b/%b", rsp_id, rsp_data, flags, flags_m, id, e[7:0], m1, m2);
          end
        end
      end
      if (|req_ready) begin
        n_checks++; if (req_ready !== (mptr ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_grant got=%b ptr=%b", req_ready, mptr); end
        if (last >= 0) begin
          n_checks++; if (cyc - last != 3) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        acc++;
        q.push_back(int'(mptr));
        mptr = ~mptr;
      end
      tick();
    end
    n_checks++; if (acc != 4 || rsps != 4 || q.size() != 0) begin n_fail++; $display("FAIL b2b_count got acc=%0d rsps=%0d pending=%0d exp=4/4/0", acc, rsps, q.size()); end
  endtask

  task automatic test_backpressure();
    int w;
    logic [11:0] e;
    logic [7:0] a = 8'($urandom), b = 8'($urandom);
    logic sub = 1'($urandom);
    e = ref_op(a, b, sub);
    rsp_ready = 1'b0;
    accept(1, a, b, sub, w);
    tick();
    m1 = e[11:8];
    m2 = (m2 & 4'b1011) | (e[11:8] & 4'b0100);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== e[7:0] || flags !== m1 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL hold_c%0d got v=%b id=%b d=%h f=%b rdy=%b exp v=1 id=1 d=%h f=%b rdy=00", i, rsp_valid, rsp_id, rsp_data, flags, req_ready, e[7:0], m1);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin n_fail++; $display("FAIL hold_release got v=%b rdy=%b exp v=0 rdy=01", rsp_valid, req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_reset_mid();
    int w;
    accept(0, 8'hFF, 8'h01, 1'b0, w);
    reset = 1'b0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || flags !== 4'b0000 || flags_m !== 4'b0000) begin n_fail++; $display("FAIL midrst got v=%b f=%b/%b exp v=0 f=0000", rsp_valid, flags, flags_m); end
    n_checks++; if (req_ready !== 2'b00 || alu_in1 !== 8'h00) begin n_fail++; $display("FAIL midrst_idle got rdy=%b in1=%h exp 00/00", req_ready, alu_in1); end
    reset = 1'b1;
    m1 = 4'b0000; m2 = 4'b0000; mptr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b0 || rsp_valid_m !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost_c%0d got v=%b/%b exp 0", i, rsp_valid, rsp_valid_m); end
      tick();
    end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_ptr got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) test_op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    tick();
    test_op(0, 8'h7F, 8'h01, 1'b0);
    test_op(1, 8'h05, 8'h05, 1'b1);
    test_op(0, 8'h00, 8'h01, 1'b1);
    test_back_to_back();
    test_backpressure();
    test_op(0, 8'h80, 8'h80, 1'b0);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
